// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the post-FFT magnitude stage.
package fft_pkg;

    localparam int N_BINS = 64;
    localparam int LOG2_N = $clog2(N_BINS);
    localparam int DATA_W = 16;
    localparam int MAG_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_mag_stage_if.sv
// Control, FFT-RAM read port, O_RAM write port and peak result of the magnitude stage.
interface fft_mag_stage_if #(
    parameter int N      = fft_pkg::N_BINS,
    parameter int DATA_W = fft_pkg::DATA_W
);
    localparam int AW = $clog2(N);
    localparam int MW = 2 * DATA_W;

    logic                     start;
    logic                     busy;
    logic                     done;
    logic [AW-1:0]            fft_addr;
    logic signed [DATA_W-1:0] fft_re;
    logic signed [DATA_W-1:0] fft_im;
    logic                     mag_we;
    logic [AW-1:0]            mag_addr;
    logic [MW-1:0]            mag_data;
    logic [AW-1:0]            peak_bin;
    logic [MW-1:0]            peak_mag;

    modport master (
        output start, fft_re, fft_im,
        input  busy, done, fft_addr, mag_we, mag_addr, mag_data, peak_bin, peak_mag
    );

    modport slave (
        input  start, fft_re, fft_im,
        output busy, done, fft_addr, mag_we, mag_addr, mag_data, peak_bin, peak_mag
    );

endinterface

// File: rtl/mag_sq_pipe.sv
// Two-stage re^2 + im^2 pipeline; valid and bin index travel alongside the data.
module mag_sq_pipe #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int IDX_W  = fft_pkg::LOG2_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    output logic [2*DATA_W-1:0]      out_mag
);
    localparam int MW = 2 * DATA_W;

    logic signed [DATA_W-1:0] comp [2];
    logic                     s2_valid_reg;
    logic [IDX_W-1:0]         s2_idx_reg;
    logic                     s3_valid_reg;
    logic [IDX_W-1:0]         s3_idx_reg;
    logic [MW-1:0]            mag_reg;

    assign comp[0] = in_re;
    assign comp[1] = in_im;

    // A square of a DATA_W-bit signed value is never negative and fits in MW-1 bits.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sq
            logic signed [MW-1:0] prod;
            logic [MW-1:0]        sq_reg;

            assign prod = MW'(comp[gi]) * MW'(comp[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sq_reg <= '0;
                end else if (in_valid) begin
                    sq_reg <= $unsigned(prod);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_idx_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_idx_reg   <= '0;
            mag_reg      <= '0;
        end else begin
            s2_valid_reg <= in_valid;
            s3_valid_reg <= s2_valid_reg;
            if (in_valid) begin
                s2_idx_reg <= in_idx;
            end
            if (s2_valid_reg) begin
                s3_idx_reg <= s2_idx_reg;
                mag_reg    <= g_sq[0].sq_reg + g_sq[1].sq_reg;
            end
        end
    end

    assign out_valid = s3_valid_reg;
    assign out_idx   = s3_idx_reg;
    assign out_mag   = mag_reg;

endmodule

// File: rtl/fft_mag_stage.sv
// Streams the FFT result RAM through the squared-magnitude pipe into O_RAM and tracks the peak bin.
module fft_mag_stage #(
    parameter int N       = fft_pkg::N_BINS,
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    fft_mag_stage_if.slave  bus
);
    import fft_pkg::*;

    localparam int AW = $clog2(N);
    localparam int MW = 2 * DATA_W;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [1:0]    drain_reg, drain_next;
    logic          clear_peak;

    logic          s1_valid_reg;
    logic [AW-1:0] s1_idx_reg;
    logic          pipe_valid;
    logic [AW-1:0] pipe_idx;
    logic [MW-1:0] pipe_mag;
    logic          is_cand;
    logic [AW-1:0] peak_bin_reg;
    logic [MW-1:0] peak_mag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            drain_reg <= drain_next;
        end
    end

    // DRAIN lasts three cycles: the RAM read stage plus the two pipe stages behind the last address.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        drain_next = drain_reg;
        clear_peak = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_next  = '0;
                    drain_next = '0;
                    clear_peak = 1'b1;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (addr_reg == AW'(N - 1)) begin
                    drain_next = '0;
                    state_next = ST_DRAIN;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_reg == 2'd2) begin
                    state_next = ST_DONE;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // RAM data arrives one cycle after its address, so tag it with the delayed address.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= '0;
        end else begin
            s1_valid_reg <= (state_reg == ST_READ);
            s1_idx_reg   <= addr_reg;
        end
    end

    mag_sq_pipe #(
        .DATA_W (DATA_W),
        .IDX_W  (AW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_reg),
        .in_idx    (s1_idx_reg),
        .in_re     (bus.fft_re),
        .in_im     (bus.fft_im),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx),
        .out_mag   (pipe_mag)
    );

    generate
        if (SKIP_DC) begin : g_skip_dc
            assign is_cand = pipe_valid && (pipe_idx != '0);
        end else begin : g_all_bins
            assign is_cand = pipe_valid;
        end
    endgenerate

    // Strict compare keeps the lowest bin on ties.
    always_ff @(posedge clk) begin
        if (rst || clear_peak) begin
            peak_bin_reg <= '0;
            peak_mag_reg <= '0;
        end else if (is_cand && (pipe_mag > peak_mag_reg)) begin
            peak_bin_reg <= pipe_idx;
            peak_mag_reg <= pipe_mag;
        end
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.fft_addr = addr_reg;
    assign bus.mag_we   = pipe_valid;
    assign bus.mag_addr = pipe_idx;
    assign bus.mag_data = pipe_mag;
    assign bus.peak_bin = peak_bin_reg;
    assign bus.peak_mag = peak_mag_reg;

endmodule

// File: tb/tb_fft_mag_stage.sv
// Self-checking bench for fft_mag_stage: per-cycle output logs compared against a bin-level model.
module tb_fft_mag_stage;
    import fft_pkg::*;

    localparam int LOG_LEN = 320;
    localparam int PASS    = N_BINS + 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   log_en = 1'b0;

    int re_mem [N_BINS];
    int im_mem [N_BINS];

    bit     we_log   [LOG_LEN];
    bit     done_log [LOG_LEN];
    bit     busy_log [LOG_LEN];
    int     addr_log [LOG_LEN];
    int     fa_log   [LOG_LEN];
    int     pbin_log [LOG_LEN];
    longint data_log [LOG_LEN];
    longint pmag_log [LOG_LEN];

    fft_mag_stage_if #(.N(N_BINS), .DATA_W(DATA_W)) bus ();

    fft_mag_stage #(.N(N_BINS), .DATA_W(DATA_W), .SKIP_DC(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FFT result RAM with registered read
    always @(posedge clk) begin
        bus.fft_re <= DATA_W'(re_mem[bus.fft_addr]);
        bus.fft_im <= DATA_W'(im_mem[bus.fft_addr]);
    end

    always @(negedge clk) begin
        #1;
        if (log_en && (cyc - t0) < LOG_LEN) begin
            we_log[cyc - t0]   <= bus.mag_we;
            done_log[cyc - t0] <= bus.done;
            busy_log[cyc - t0] <= bus.busy;
            addr_log[cyc - t0] <= int'(bus.mag_addr);
            fa_log[cyc - t0]   <= int'(bus.fft_addr);
            pbin_log[cyc - t0] <= int'(bus.peak_bin);
            data_log[cyc - t0] <= longint'(bus.mag_data);
            pmag_log[cyc - t0] <= longint'(bus.peak_mag);
        end
    end

    task automatic load_pattern(input int pat);
        for (int k = 0; k < N_BINS; k++) begin
            case (pat)
                0: begin re_mem[k] = k; im_mem[k] = 0; end
                3: begin
                    re_mem[k] = int'($urandom_range(65535)) - 32768;
                    im_mem[k] = int'($urandom_range(65535)) - 32768;
                end
                4: begin
                    re_mem[k] = int'($urandom_range(4)) - 2;
                    im_mem[k] = int'($urandom_range(4)) - 2;
                end
                default: begin re_mem[k] = 0; im_mem[k] = 0; end
            endcase
        end
        if (pat == 1) begin
            re_mem[5] = -32768; im_mem[5] = -32768;
        end
        if (pat == 2) begin
            re_mem[0] = 100;
            re_mem[10] = 3; im_mem[10] = 4;
            re_mem[20] = 3; im_mem[20] = 4;
        end
    endtask

    function automatic longint bin_mag(input int k);
        return longint'(re_mem[k]) * longint'(re_mem[k]) + longint'(im_mem[k]) * longint'(im_mem[k]);
    endfunction

    // Peak search over bins 1..N-1 (DC excluded), first maximum wins.
    task automatic model_peak(output int pbin, output longint pmag);
        pbin = 0;
        pmag = 0;
        for (int k = 1; k < N_BINS; k++) begin
            if (bin_mag(k) > pmag) begin
                pbin = k;
                pmag = bin_mag(k);
            end
        end
    endtask

    // Runs `cycles` cycles from a start in relative cycle 0; cycle c uses the inputs chosen here.
    task automatic drive(input int cycles, input int hold, input int extra_at, input int rst_at);
        @(negedge clk);
        t0 = cyc;
        log_en = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            bus.start = (c < hold) || (c == extra_at);
            rst = (c == rst_at);
            @(negedge clk);
        end
        log_en = 1'b0;
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mag_we !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got busy=%b done=%b we=%b, expected 0 0 0", bus.busy, bus.done, bus.mag_we);
        end
        checks++; if (bus.fft_addr !== '0 || bus.mag_addr !== '0 || bus.mag_data !== '0) begin
            errors++; $display("FAIL reset_data: got fft_addr=%0d mag_addr=%0d mag_data=%0d, expected 0 0 0", bus.fft_addr, bus.mag_addr, bus.mag_data);
        end
        checks++; if (bus.peak_bin !== '0 || bus.peak_mag !== '0) begin
            errors++; $display("FAIL reset_peak: got bin=%0d mag=%0d, expected 0 0", bus.peak_bin, bus.peak_mag);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.mag_we !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: got busy=%b we=%b, expected 0 0", bus.busy, bus.mag_we);
        end
        $display("test_reset done");
    endtask

    task automatic test_pattern(input string name, input int pat);
        int     nwe;
        int     exp_bin;
        longint exp_peak;
        load_pattern(pat);
        model_peak(exp_bin, exp_peak);
        drive(PASS + 11, 1, -1, -1);
        nwe = 0;
        for (int c = 0; c < PASS + 11; c++) if (we_log[c]) nwe++;
        checks++; if (nwe != N_BINS) begin
            errors++; $display("FAIL %s write_count: got %0d, expected %0d", name, nwe, N_BINS);
        end
        for (int k = 0; k < N_BINS; k++) begin
            checks++; if (we_log[k+4] !== 1'b1 || addr_log[k+4] != k || data_log[k+4] != bin_mag(k)) begin
                errors++; $display("FAIL %s write_bin%0d: got we=%b addr=%0d data=%0d, expected we=1 addr=%0d data=%0d",
                                   name, k, we_log[k+4], addr_log[k+4], data_log[k+4], k, bin_mag(k));
            end
            checks++; if (fa_log[k+1] != k) begin
                errors++; $display("FAIL %s fft_addr_c%0d: got %0d, expected %0d", name, k + 1, fa_log[k+1], k);
            end
        end
        for (int c = 0; c < PASS + 11; c++) begin
            checks++; if (done_log[c] !== (c == N_BINS + 4) || busy_log[c] !== (c >= 1 && c <= N_BINS + 4)) begin
                errors++; $display("FAIL %s ctrl_c%0d: got done=%b busy=%b, expected done=%b busy=%b", name, c,
                                   done_log[c], busy_log[c], (c == N_BINS + 4), (c >= 1 && c <= N_BINS + 4));
            end
        end
        checks++; if (fa_log[N_BINS + 4] != N_BINS - 1 || fa_log[PASS + 10] != N_BINS - 1) begin
            errors++; $display("FAIL %s fft_addr_hold: got %0d/%0d, expected %0d", name, fa_log[N_BINS + 4], fa_log[PASS + 10], N_BINS - 1);
        end
        checks++; if (pbin_log[N_BINS + 4] != exp_bin || pmag_log[N_BINS + 4] != exp_peak) begin
            errors++; $display("FAIL %s peak_at_done: got bin=%0d mag=%0d, expected bin=%0d mag=%0d", name,
                               pbin_log[N_BINS + 4], pmag_log[N_BINS + 4], exp_bin, exp_peak);
        end
        checks++; if (pbin_log[PASS + 10] != exp_bin || pmag_log[PASS + 10] != exp_peak) begin
            errors++; $display("FAIL %s peak_hold: got bin=%0d mag=%0d, expected bin=%0d mag=%0d", name,
                               pbin_log[PASS + 10], pmag_log[PASS + 10], exp_bin, exp_peak);
        end
        $display("test_pattern %s: peak bin=%0d mag=%0d", name, exp_bin, exp_peak);
    endtask

    task automatic test_start_while_busy();
        int nwe;
        int ndone;
        load_pattern(3);
        drive(PASS + 30, 1, 30, -1);
        nwe = 0;
        ndone = 0;
        for (int c = 0; c < PASS + 30; c++) begin
            if (we_log[c]) nwe++;
            if (done_log[c]) ndone++;
        end
        checks++; if (nwe != N_BINS || ndone != 1 || done_log[N_BINS + 4] !== 1'b1) begin
            errors++; $display("FAIL busy_start: got writes=%0d dones=%0d done@68=%b, expected %0d 1 1", nwe, ndone, done_log[N_BINS + 4], N_BINS);
        end
        checks++; if (busy_log[PASS + 20] !== 1'b0) begin
            errors++; $display("FAIL busy_start_idle: got busy=%b after pass, expected 0", busy_log[PASS + 20]);
        end
        $display("test_start_while_busy done");
    endtask

    task automatic test_continuous();
        int ndone;
        load_pattern(0);
        drive(3 * PASS + 8, 3 * PASS + 8, -1, -1);
        ndone = 0;
        for (int c = 0; c < 3 * PASS + 8; c++) if (done_log[c]) ndone++;
        for (int p = 0; p < 3; p++) begin
            checks++; if (done_log[p * PASS + N_BINS + 4] !== 1'b1 || pmag_log[p * PASS + N_BINS + 4] != 3969 ||
                          pbin_log[p * PASS + N_BINS + 4] != N_BINS - 1) begin
                errors++; $display("FAIL cont_done%0d: got done=%b bin=%0d mag=%0d, expected 1 %0d 3969", p,
                                   done_log[p * PASS + N_BINS + 4], pbin_log[p * PASS + N_BINS + 4], pmag_log[p * PASS + N_BINS + 4], N_BINS - 1);
            end
            checks++; if (pmag_log[p * PASS + 1] != 0 || pbin_log[p * PASS + 1] != 0) begin
                errors++; $display("FAIL cont_clear%0d: got bin=%0d mag=%0d, expected 0 0", p, pbin_log[p * PASS + 1], pmag_log[p * PASS + 1]);
            end
        end
        checks++; if (ndone != 3) begin
            errors++; $display("FAIL cont_done_count: got %0d, expected 3", ndone);
        end
        rst = 1'b0;
        repeat (PASS + 5) @(negedge clk);
        $display("test_continuous done");
    endtask

    task automatic test_reset_mid_pass();
        int bad;
        load_pattern(3);
        drive(100, 1, -1, 20);
        checks++; if (we_log[21] !== 1'b0 || busy_log[21] !== 1'b0 || done_log[21] !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got we=%b busy=%b done=%b, expected 0 0 0", we_log[21], busy_log[21], done_log[21]);
        end
        checks++; if (fa_log[21] != 0 || addr_log[21] != 0 || data_log[21] != 0 || pbin_log[21] != 0 || pmag_log[21] != 0) begin
            errors++; $display("FAIL midrst_values: got fa=%0d addr=%0d data=%0d pbin=%0d pmag=%0d, expected all 0",
                               fa_log[21], addr_log[21], data_log[21], pbin_log[21], pmag_log[21]);
        end
        bad = 0;
        for (int c = 21; c < 100; c++) if (we_log[c] || done_log[c] || busy_log[c]) bad++;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL midrst_quiet: got %0d active cycles after reset, expected 0", bad);
        end
        $display("test_reset_mid_pass done");
    endtask

    initial begin
        bus.start = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < N_BINS; k++) begin re_mem[k] = 0; im_mem[k] = 0; end
        test_reset();
        test_pattern("basic_ramp", 0);
        test_pattern("extreme", 1);
        test_pattern("dc_skip_ties", 2);
        test_pattern("random_full", 3);
        test_pattern("random_small", 4);
        test_pattern("all_zero", 5);
        test_start_while_busy();
        test_continuous();
        test_reset_mid_pass();
        test_pattern("post_reset", 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_mag_stage.md
# fft_mag_stage

Post-FFT magnitude stage. Streams the 64-bin complex spectrum out of the FFT result RAM, computes the squared magnitude re²+im² per bin, and writes it into O_RAM for the magnitude readout state. While streaming it tracks the largest bin, so the controller can report the dominant frequency without a second pass. It is started once per window by the main state machine, after the FFT completes.

## Interface

Parameters:
- N, 64: number of FFT bins (power of two).
- DATA_W, 16: width of signed real and imaginary inputs.
- SKIP_DC, 1: when 1, bin 0 is written to O_RAM but excluded from peak search.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when the pass is complete and the peak outputs are final.
- fft_addr  out  log2(N)  read address to the FFT result RAM (registered).
- fft_re  in  DATA_W  signed real part; valid one cycle after fft_addr.
- fft_im  in  DATA_W  signed imaginary part; valid one cycle after fft_addr.
- mag_we  out  1  O_RAM write enable.
- mag_addr  out  log2(N)  O_RAM write address.
- mag_data  out  2*DATA_W  unsigned re²+im².
- peak_bin  out  log2(N)  index of the largest magnitude seen in the current or last pass.
- peak_mag  out  2*DATA_W  magnitude at peak_bin.

## Operation

- States: IDLE → READ → DRAIN → DONE → IDLE.
- **IDLE:** on start=1, set fft_addr to 0, clear peak_bin and peak_mag to 0, and go to READ.
- **READ:** fft_addr increments once per cycle. When fft_addr=N-1, go to DRAIN.
- **DRAIN:** wait 3 cycles until the last write issues, then go to DONE.
- **DONE:** pulse done, then return to IDLE.
- **Pipeline (one bin per cycle):**
  - S1: the RAM output is valid.
  - S2: register re² and im², each an unsigned 2*DATA_W-bit value.
  - S3: register the sum into mag_data, drive mag_addr with the bin index, and set mag_we=1.
- **Arithmetic:**
  - Use full-precision signed multiply.
  - The sum is 2*DATA_W bits unsigned.
  - The worst case (-2^(DATA_W-1))² ×2 = 2^(2*DATA_W-1) fits, so no saturation logic is needed.
- **Peak update:**
  - Evaluated on each mag_we cycle.
  - Replace the peak only if mag_data > peak_mag (strict), so ties keep the lowest bin.
  - With SKIP_DC=1, bin 0 is never a candidate.
  - If all candidates are 0, the pass ends with peak_bin=0 and peak_mag=0.
- **start handling:** start while busy is ignored. If start is held high continuously, a new pass begins in the IDLE cycle after DONE.
- **rst mid-pass:** on the next edge all state returns to reset values. No further mag_we is asserted and done does not pulse. A partially written O_RAM is acceptable.

## Timing

- Reset values:
  - state=IDLE
  - busy=0, done=0, mag_we=0
  - fft_addr=0, mag_addr=0, mag_data=0
  - peak_bin=0, peak_mag=0
- With start accepted in cycle 0:
  - fft_addr=k in cycle k+1, for k=0..N-1.
  - Bin k is written (mag_we=1) in cycle k+4.
  - mag_we is high for exactly N consecutive cycles, from cycle 4 through N+3.
  - done is high in cycle N+4. peak_bin and peak_mag are final in that cycle and hold until the next start is accepted.
- Pass length: N+5 cycles from start to the next accept opportunity (69 for N=64).
- fft_addr holds N-1 during DRAIN and DONE, and returns to 0 only on the next accept.

## Structure

- Shared package fft_pkg:
  - N_BINS, LOG2_N, DATA_W, MAG_W=2*DATA_W
  - state encoding enum for IDLE, READ, DRAIN, DONE
- Sub-module mag_sq_pipe: the 2-stage square-and-add pipeline, with a valid and an index carried alongside. The top level holds the FSM, the address counter and the peak tracker.

## Test plan

- **Basic pass:** RAM model with re=k, im=0 for bin k → mag_data=k² at mag_addr=k in cycle k+4. 64 writes. done in cycle 68. peak_bin=63, peak_mag=3969.
- **Extreme values:** bin 5 holds re=-32768, im=-32768 and all other bins are 0 → mag_data=0x80000000 at bin 5. peak_bin=5, peak_mag=0x80000000.
- **DC skip and ties:**
  - bin 0 = (100,0); bins 10 and 20 = (3,4); others 0.
  - Expect bin 0 written as 10000, peak_bin=10, peak_mag=25.
- **Start while busy:** pulse start again in cycle 30 → ignored; still exactly 64 writes and one done, in cycle 68.
- **Continuous start:** hold start=1 → done pulses in cycles 68, 137 and 206. Peak is cleared at each accept.
- **Reset mid-pass:** assert rst in cycle 20 for 1 cycle → from the next cycle mag_we=0, busy=0, and all outputs at reset values. No done pulse. A subsequent start runs a clean full pass.
